// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package seven_seg_pkg;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned SRC_W   = 16;

  localparam logic [SRC_W-1:0] BLANK_VALUE = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHOW,
    ST_ALERT
  } state_t;

endpackage

// File: rtl/seven_seg_rr_pick.sv
// Round-robin source pick: first enabled index in order cur+1, cur+2, cur+3, cur.
module seven_seg_rr_pick (
  input  logic [3:0] enable,
  input  logic [1:0] cur,
  output logic [1:0] nxt,
  output logic       any
);

  logic [1:0] cand;
  logic       found;

  always_comb begin
    nxt   = cur;
    any   = |enable;
    cand  = cur;
    found = 1'b0;
    // k = 4 wraps back to cur, so the current index is searched last
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = cur + 2'(k);
      if (!found && enable[cand]) begin
        nxt   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_segment_display_arbiter.sv
// Time-shares the 4-digit display between four shadowed status sources and an alert channel.
module seven_segment_display_arbiter
  import seven_seg_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 100000000,
  parameter int unsigned CNT_W        = 27
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] src_data,
  input  logic [3:0]  src_load,
  input  logic [3:0]  src_enable,
  input  logic        alert_valid,
  input  logic [15:0] alert_data,
  input  logic        next_btn,
  output logic [15:0] disp_data,
  output logic [1:0]  disp_sel,
  output logic        disp_blank,
  output logic        alert_active
);

  logic [SRC_W-1:0] shadow   [NUM_SRC];
  logic [SRC_W-1:0] shadow_n [NUM_SRC];

  state_t           state, state_n;
  logic [1:0]       sel, sel_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [15:0]      disp_data_n;

  logic [1:0] pick_nxt, low_nxt;
  logic       pick_any, low_any;
  logic       dwell_done;

  seven_seg_rr_pick u_pick (
    .enable (src_enable),
    .cur    (sel),
    .nxt    (pick_nxt),
    .any    (pick_any)
  );

  // Searching from index 3 visits 0,1,2,3 first, yielding the lowest enabled source
  seven_seg_rr_pick u_lowest (
    .enable (src_enable),
    .cur    (2'd3),
    .nxt    (low_nxt),
    .any    (low_any)
  );

  assign dwell_done = (cnt == CNT_W'(DWELL_CYCLES - 1));

  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      shadow_n[i] = src_load[i] ? src_data[SRC_W*i +: SRC_W] : shadow[i];
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel;
    cnt_n   = cnt;
    case (state)
      ST_IDLE: begin
        if (alert_valid) begin
          state_n = ST_ALERT;
        end else if (low_any) begin
          state_n = ST_SHOW;
          sel_n   = low_nxt;
          cnt_n   = '0;
        end
      end
      ST_SHOW: begin
        if (alert_valid) begin
          state_n = ST_ALERT;
        end else if (!pick_any) begin
          state_n = ST_IDLE;
        end else if (!src_enable[sel] || next_btn || dwell_done) begin
          sel_n = pick_nxt;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_ALERT: begin
        if (!alert_valid) begin
          if (src_enable[sel]) begin
            state_n = ST_SHOW;
            cnt_n   = '0;
          end else if (pick_any) begin
            state_n = ST_SHOW;
            sel_n   = pick_nxt;
            cnt_n   = '0;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    case (state_n)
      ST_SHOW:  disp_data_n = shadow_n[sel_n];
      ST_ALERT: disp_data_n = alert_data;
      default:  disp_data_n = BLANK_VALUE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        shadow[i] <= shadow_n[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      sel          <= '0;
      cnt          <= '0;
      disp_data    <= BLANK_VALUE;
      disp_blank   <= 1'b1;
      alert_active <= 1'b0;
    end else begin
      state        <= state_n;
      sel          <= sel_n;
      cnt          <= cnt_n;
      disp_data    <= disp_data_n;
      disp_blank   <= (state_n == ST_IDLE);
      alert_active <= (state_n == ST_ALERT);
    end
  end

  assign disp_sel = sel;

endmodule

// File: tb/tb_seven_segment_display_arbiter.sv
// Scoreboard bench for seven_segment_display_arbiter with DWELL_CYCLES = 8.
module tb_seven_segment_display_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] src_data;
  logic [3:0]  src_load;
  logic [3:0]  src_enable;
  logic        alert_valid;
  logic [15:0] alert_data;
  logic        next_btn;
  logic [15:0] disp_data;
  logic [1:0]  disp_sel;
  logic        disp_blank;
  logic        alert_active;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  sel;
    logic        blank;
    logic        alert;
    int          tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step     = 0;

  seven_segment_display_arbiter #(
    .DWELL_CYCLES (8),
    .CNT_W        (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .src_data     (src_data),
    .src_load     (src_load),
    .src_enable   (src_enable),
    .alert_valid  (alert_valid),
    .alert_data   (alert_data),
    .next_btn     (next_btn),
    .disp_data    (disp_data),
    .disp_sel     (disp_sel),
    .disp_blank   (disp_blank),
    .alert_active (alert_active)
  );

  always #5 clk = ~clk;

  function automatic void check(input int tag, input logic [15:0] ed, input logic [1:0] es,
                                input logic eb, input logic ea);
    n_checks++;
    if (disp_data !== ed || disp_sel !== es || disp_blank !== eb || alert_active !== ea) begin
      n_fail++;
      $display("FAIL step %0d: got data=%h sel=%0d blank=%b alert=%b, expected data=%h sel=%0d blank=%b alert=%b",
               tag, disp_data, disp_sel, disp_blank, alert_active, ed, es, eb, ea);
    end
  endfunction

  // Monitor: one expected entry per clock edge, sampled on the falling edge
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check(mon_e.tag, mon_e.data, mon_e.sel, mon_e.blank, mon_e.alert);
    end
  end

  // Queue the expected outputs after the coming edge, then let that edge happen
  task automatic tick(input logic [15:0] ed, input logic [1:0] es, input logic eb, input logic ea);
    exp_t e;
    e.data  = ed;
    e.sel   = es;
    e.blank = eb;
    e.alert = ea;
    e.tag   = step;
    step++;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
    src_load = '0;
    next_btn = 1'b0;
  endtask

  task automatic show(input int n, input logic [15:0] ed, input logic [1:0] es);
    for (int i = 0; i < n; i++) tick(ed, es, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b1;
    src_data    = '0;
    src_load    = '0;
    src_enable  = '0;
    alert_valid = 1'b0;
    alert_data  = '0;
    next_btn    = 1'b0;
    #1 reset_n = 1'b0;
    #2 check(-1, 16'h0000, 2'd0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (4) tick(16'h0000, 2'd0, 1'b1, 1'b0);

    // Rotation over sources 0,1,3
    src_data = 64'h4444_3333_2222_1111;
    src_load = 4'hF;
    tick(16'h0000, 2'd0, 1'b1, 1'b0);
    src_enable = 4'b1011;
    show(8, 16'h1111, 2'd0);
    show(8, 16'h2222, 2'd1);
    show(8, 16'h4444, 2'd3);
    show(8, 16'h1111, 2'd0);

    // Disable the shown source mid-dwell
    show(2, 16'h2222, 2'd1);
    src_enable = 4'b1001;
    tick(16'h4444, 2'd3, 1'b0, 1'b0);
    src_enable = 4'b1011;
    show(7, 16'h4444, 2'd3);

    // Manual advance restarts the dwell
    show(3, 16'h1111, 2'd0);
    next_btn = 1'b1;
    show(8, 16'h2222, 2'd1);
    show(8, 16'h4444, 2'd3);
    show(8, 16'h1111, 2'd0);
    show(6, 16'h2222, 2'd1);

    // Alert preempts source 1 at counter 5
    alert_valid = 1'b1;
    alert_data  = 16'hDEAD;
    for (int i = 0; i < 20; i++) begin
      if (i == 4) next_btn = 1'b1;
      if (i == 9) begin
        src_data[31:16] = 16'hBEEF;
        src_load = 4'b0010;
      end
      alert_data = (i == 14) ? 16'hCAFE : 16'hDEAD;
      tick((i == 14) ? 16'hCAFE : 16'hDEAD, 2'd1, 1'b0, 1'b1);
    end
    alert_valid = 1'b0;
    show(8, 16'hBEEF, 2'd1);
    tick(16'h4444, 2'd3, 1'b0, 1'b0);

    // Only source 2 enabled: button on the terminal cycle gives one restart
    src_enable = 4'b0100;
    show(8, 16'h3333, 2'd2);
    next_btn = 1'b1;
    tick(16'h3333, 2'd2, 1'b0, 1'b0);
    show(6, 16'h3333, 2'd2);
    src_enable = 4'b0110;
    tick(16'h3333, 2'd2, 1'b0, 1'b0);
    tick(16'hBEEF, 2'd1, 1'b0, 1'b0);

    // Asynchronous reset between edges
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check(-2, 16'h0000, 2'd0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    tick(16'h0000, 2'd0, 1'b1, 1'b0);
    reset_n = 1'b1;
    tick(16'h0000, 2'd1, 1'b0, 1'b0);
    src_load = 4'b0010;
    tick(16'hBEEF, 2'd1, 1'b0, 1'b0);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_segment_display_arbiter.md
# seven_segment_display_arbiter

Time-shares the 4-digit hex seven-segment display between four 16-bit status sources and one priority alert channel. Each source's value is captured into a shadow register. The enabled sources are rotated round-robin with a programmable dwell time. A manual-advance pulse and an alert override are supported. The block drives the `data_in` port of the existing seven-segment driver and sits between the accelerator status/debug signals and that driver.

## Interface
- `DWELL_CYCLES`, default 100000000: cycles each source is shown (1 s at 100 MHz); legal range ≥ 2.
- `CNT_W`, default 27: dwell counter width; must satisfy 2^CNT_W ≥ DWELL_CYCLES.
- `clk`  in  1  100 MHz system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `src_data`  in  64  packed source values; source i on [16i+15:16i].
- `src_load`  in  4  per-source single-cycle capture strobe.
- `src_enable`  in  4  level; source i participates in rotation.
- `alert_valid`  in  1  level; while high, alert_data preempts rotation.
- `alert_data`  in  16  alert value.
- `next_btn`  in  1  single-cycle, already-debounced manual advance.
- `disp_data`  out  16  value for the driver's `data_in`.
- `disp_sel`  out  2  index of the source currently selected.
- `disp_blank`  out  1  high when nothing is shown (IDLE).
- `alert_active`  out  1  high while in ALERT.

## Operation
- All outputs are registers, computed each edge from next-state values, so they reflect that edge's decisions with no extra delay.
- **Reset** (reset_n low, async):
  - Shadows cleared to 0 and dwell counter to 0.
  - state = IDLE, disp_data = 0, disp_sel = 0, disp_blank = 1, alert_active = 0.
- **Shadows.** src_load[i] high at an edge: shadow[i] ← src_data[16i+15:16i]. This applies in every state, including ALERT. Loads to several sources in the same cycle are all captured.
- **States:** IDLE, SHOW, ALERT.
- **Rotation pick.** Search order is sel+1, sel+2, sel+3, then sel (mod 4). The first enabled index is chosen.
- **IDLE.**
  - alert_valid → ALERT.
  - Otherwise, any src_enable bit set → SHOW on the lowest enabled index, counter = 0.
- **SHOW.**
  - alert_valid has the highest priority → ALERT. sel and the counter are frozen.
  - Else, src_enable all zero → IDLE (disp_sel keeps its last value).
  - Else, advance on any of:
    - src_enable[sel] == 0;
    - next_btn;
    - counter == DWELL_CYCLES−1.
  - On advance: sel ← rotation pick, counter ← 0. Simultaneous causes produce exactly one advance.
  - If only sel is enabled, sel is unchanged and the counter restarts.
  - Otherwise the counter increments.
- **ALERT.**
  - Output: disp_data = alert_data (tracked live each cycle), alert_active = 1, disp_blank = 0.
  - next_btn is ignored.
  - When alert_valid falls:
    - If src_enable[sel] is still set → SHOW on the same sel, counter = 0.
    - Else if any source is enabled → SHOW on the rotation pick.
    - Else → IDLE.
- **disp_data by state:**
  - SHOW: shadow[sel], including a same-edge load into that shadow.
  - IDLE: 0.
  - ALERT: alert_data.

## Timing
- src_load on edge t, source selected: new value on disp_data after edge t (latency 1).
- alert_valid rising at edge t: alert_active = 1 and disp_data = alert_data after edge t. Falling at edge t: rotation display resumes after edge t.
- Dwell: a source entered at edge t is shown for exactly DWELL_CYCLES cycles. The advance occurs at edge t+DWELL_CYCLES.
- next_btn at edge t: the new sel appears after edge t; the counter restarts from 0.
- Reset assertion mid-operation clears all state immediately. Deassertion is synchronous to clk at the integration level.

## Structure
- Package `seven_seg_pkg` holds:
  - the state enum (IDLE/SHOW/ALERT);
  - NUM_SRC = 4 and SRC_W = 16;
  - the blank value, 16'h0000.
- Sub-module `seven_seg_rr_pick` is combinational. Inputs: enable[3:0] and cur[1:0]. Outputs: nxt[1:0] and any. It implements the rotation search order and is shared by the SHOW advance and the ALERT exit.
- The top level contains the FSM, the dwell counter, the shadow register file and the output registers.

## Test plan
All scenarios use DWELL_CYCLES = 8.
- **Reset/idle.** Hold reset_n low, then release with src_enable = 0 → disp_blank = 1, disp_data = 0, disp_sel = 0 indefinitely.
- **Rotation.**
  - Stimulus: load shadows 0..3 with 16'h1111, 2222, 3333, 4444; then src_enable = 4'b1011.
  - Response: disp_sel sequence 0,1,3,0, each held exactly 8 cycles; disp_data matches each shadow.
- **Manual and disable.**
  - next_btn on cycle 3 of source 0 → source 1 shown after that edge with a full 8-cycle dwell.
  - Clearing src_enable[1] mid-dwell → advance to 3 on the next edge.
- **Alert preempt.**
  - Stimulus: while on source 1 at counter 5, raise alert_valid with alert_data = 16'hDEAD for 20 cycles; issue next_btn and src_load[1] = 16'hBEEF inside the alert window.
  - Response: disp_data = DEAD and next_btn ignored during the alert; afterwards, source 1 is shown as BEEF for 8 cycles.
- **Simultaneous events.** next_btn on the dwell-terminal cycle with only source 2 enabled → sel stays 2 and the counter restarts; exactly one dwell period follows.
- **Async reset mid-SHOW.** Pull reset_n low between clock edges → all outputs return to reset values without waiting for a clock edge.
